// File: rtl/cmos_reg_cfg_pkg.sv
// Shared definitions for the CMOS sensor power-up register sequencer:
// i2c_master command bits, sequencer state encoding and a state helper.
package cmos_reg_cfg_pkg;

    // Command bits understood by i2c_master; OR them to combine.
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0100;
    localparam logic [3:0] CMD_STOP  = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_INIT = 4'd1,
        ST_DEV       = 4'd2,
        ST_RADDR_H   = 4'd3,
        ST_RADDR_L   = 4'd4,
        ST_DATA      = 4'd5,
        ST_CHECK     = 4'd6,
        ST_GAP       = 4'd7,
        ST_FINISH    = 4'd8
    } state_e;

    // True for the states that push one byte through i2c_master.
    function automatic logic is_byte_state(input state_e s);
        return (s == ST_DEV) || (s == ST_RADDR_H) || (s == ST_RADDR_L) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/cmos_reg_cfg.sv
// Power-up register sequencer: walks the sensor register table and turns each
// entry into one SCCB/I2C write (dev addr, reg addr, data+STOP) via i2c_master.
// Handshake: req is a one-cycle strobe; cmd/din stay stable from req until the
// matching done pulse; no new req is raised before that done is seen, and done
// is ignored unless a byte is outstanding.
module cmos_reg_cfg
    import cmos_reg_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR  = 8'h78,
    parameter bit         ADDR16    = 1'b1,
    parameter int         REG_NUM   = 252,
    parameter int         INIT_DLY  = 50000,
    parameter int         GAP_CYC   = 500,
    parameter int         MAX_RETRY = 3,
    localparam int        IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [7:0]       err_cnt,
    output logic [IDX_W-1:0] lut_index,
    input  logic [23:0]      lut_data,
    output logic             req,
    output logic [3:0]       cmd,
    output logic [7:0]       din,
    input  logic             done,
    input  logic             slave_ack,
    output state_e           dbg_state
);

    localparam int CNT_MAX = (INIT_DLY > GAP_CYC) ? INIT_DLY : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // shared init-delay / bus-free counter
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sent_q, sent_d;     // req already issued for current byte
    logic               nack_q, nack_d;     // any NACK seen in this transaction
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               byte_fin;

    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_cnt   = err_cnt_q;
    assign lut_index = idx_q;
    assign dbg_state = state_q;

    // Next-state, counters and i2c_master command outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        sent_d    = sent_q;
        nack_d    = nack_q;
        done_d    = done_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        req       = 1'b0;
        cmd       = '0;
        din       = '0;
        byte_fin  = 1'b0;

        // Common byte handshake: strobe once, then wait for done.
        if (is_byte_state(state_q)) begin
            req = !sent_q;
            if (!sent_q) begin
                sent_d = 1'b1;
            end else if (done) begin
                sent_d   = 1'b0;
                nack_d   = nack_q | slave_ack;
                byte_fin = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    retry_d   = '0;
                    state_d   = ST_WAIT_INIT;
                end
            end
            ST_WAIT_INIT: begin
                if (cnt_q == CNT_W'(INIT_DLY - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DEV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEV: begin
                cmd = CMD_START | CMD_WRITE;
                din = DEV_ADDR;
                if (byte_fin) state_d = ADDR16 ? ST_RADDR_H : ST_RADDR_L;
            end
            ST_RADDR_H: begin
                cmd = CMD_WRITE;
                din = lut_data[23:16];
                if (byte_fin) state_d = ST_RADDR_L;
            end
            ST_RADDR_L: begin
                cmd = CMD_WRITE;
                din = lut_data[15:8];
                if (byte_fin) state_d = ST_DATA;
            end
            ST_DATA: begin
                cmd = CMD_WRITE | CMD_STOP;
                din = lut_data[7:0];
                if (byte_fin) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                nack_d  = 1'b0;
                state_d = ST_GAP;
                if (nack_q && (retry_q != RETRY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + RETRY_W'(1);
                end else begin
                    retry_d = '0;
                    if (nack_q) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (idx_q == IDX_W'(REG_NUM - 1)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DEV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    end

    // State and counter registers; reset self-starts the table walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT_INIT;
            cnt_q     <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            sent_q    <= 1'b0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            sent_q    <= sent_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_cmos_reg_cfg.sv
// Bench for cmos_reg_cfg: a transaction-level model of the register walk
// (entries x attempts x bytes) feeds a byte scoreboard; a behavioural slave
// answers each req with done after a random latency and NACKs on request.
module tb_cmos_reg_cfg;
    import cmos_reg_cfg_pkg::*;

    localparam int REG_NUM   = 3;
    localparam int INIT_DLY  = 20;
    localparam int GAP_CYC   = 10;
    localparam int MAX_RETRY = 3;
    localparam logic [3:0] C_SW = 4'b0011;   // START|WRITE
    localparam logic [3:0] C_W  = 4'b0010;   // WRITE
    localparam logic [3:0] C_WS = 4'b1010;   // WRITE|STOP

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;
    logic cfg_start = 1'b0;

    // main DUT (16-bit register address)
    logic        cfg_busy, cfg_done, cfg_err, req;
    logic [7:0]  err_cnt, din;
    logic [1:0]  lut_index;
    logic [23:0] lut_data;
    logic [3:0]  cmd;
    logic        done = 1'b0, slave_ack = 1'b0;
    state_e      dbg_state;

    // second DUT (8-bit register address)
    logic        busy8, done8, err8, req8;
    logic [7:0]  errc8, din8;
    logic [1:0]  idx8;
    logic [23:0] data8;
    logic [3:0]  cmd8;
    logic        done_i8 = 1'b0, ack8 = 1'b0, cfg_start8 = 1'b0;
    state_e      dbg8;

    logic [23:0] tbl  [REG_NUM];
    logic [23:0] tbl8 [REG_NUM];
    assign lut_data = tbl[lut_index];
    assign data8    = tbl8[idx8];

    cmos_reg_cfg #(.DEV_ADDR(8'h78), .ADDR16(1'b1), .REG_NUM(REG_NUM), .INIT_DLY(INIT_DLY),
                   .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .err_cnt(err_cnt), .lut_index(lut_index),
        .lut_data(lut_data), .req(req), .cmd(cmd), .din(din), .done(done),
        .slave_ack(slave_ack), .dbg_state(dbg_state));

    cmos_reg_cfg #(.DEV_ADDR(8'h78), .ADDR16(1'b0), .REG_NUM(REG_NUM), .INIT_DLY(INIT_DLY),
                   .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)) dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start8), .cfg_busy(busy8),
        .cfg_done(done8), .cfg_err(err8), .err_cnt(errc8), .lut_index(idx8),
        .lut_data(data8), .req(req8), .cmd(cmd8), .din(din8), .done(done_i8),
        .slave_ack(ack8), .dbg_state(dbg8));

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];    // {entry, cmd, din} per byte, main DUT
    logic [11:0] exp8_q [$];   // {cmd, din} per byte, 8-bit DUT
    logic [2:0]  tx_q [$];     // per transaction: {nack, nack byte position}
    logic [7:0]  slave_log [$];
    logic [7:0]  log8 [$];
    int          nack_times [REG_NUM];
    int          exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Model: each entry takes min(nacks+1, MAX_RETRY+1) attempts of 4 bytes.
    task automatic build_main();
        int att;
        exp_q.delete();
        tx_q.delete();
        exp_err = 0;
        for (int e = 0; e < REG_NUM; e++) begin
            att = (nack_times[e] > MAX_RETRY) ? MAX_RETRY + 1 : nack_times[e] + 1;
            if (nack_times[e] > MAX_RETRY) exp_err++;
            for (int a = 0; a < att; a++) begin
                exp_q.push_back({e[3:0], C_SW, 8'h78});
                exp_q.push_back({e[3:0], C_W, tbl[e][23:16]});
                exp_q.push_back({e[3:0], C_W, tbl[e][15:8]});
                exp_q.push_back({e[3:0], C_WS, tbl[e][7:0]});
                tx_q.push_back({(a < nack_times[e]) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3))});
            end
        end
        if (exp_err > 255) exp_err = 255;
    endtask

    task automatic build8();
        exp8_q.delete();
        for (int e = 0; e < REG_NUM; e++) begin
            exp8_q.push_back({C_SW, 8'h78});
            exp8_q.push_back({C_W, tbl8[e][15:8]});
            exp8_q.push_back({C_WS, tbl8[e][7:0]});
        end
    endtask

    // ---------------- slave models ----------------
    initial begin : slave_main
        bit pend, nk;
        int wait_n, pos;
        logic [2:0] tx;
        pend = 0; nk = 0; wait_n = 0; pos = 0; tx = '0;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            slave_ack = 1'b0;
            if (!rst_n) begin
                pend = 0;
                pos = 0;
                continue;
            end
            if (pend) begin
                if (wait_n == 0) begin
                    done = 1'b1;
                    slave_ack = nk && (pos == int'(tx[1:0]));
                    pend = 0;
                    pos++;
                end else begin
                    wait_n--;
                end
            end else if (req) begin
                pend = 1;
                wait_n = $urandom_range(0, 3);
                slave_log.push_back(din);
                if (cmd[0]) begin
                    pos = 0;
                    tx = (tx_q.size() > 0) ? tx_q.pop_front() : 3'b000;
                    nk = tx[2];
                end
            end
        end
    end

    initial begin : slave_8
        bit pend;
        pend = 0;
        forever begin
            @(posedge clk);
            #1;
            done_i8 = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend) begin
                done_i8 = 1'b1;
                pend = 0;
            end else if (req8) begin
                pend = 1;
                log8.push_back(din8);
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin : monitor
        bit outst;
        logic [11:0] held;
        logic [15:0] e;
        logic [11:0] e8;
        int since, want;
        outst = 0; held = '0; since = 0; want = INIT_DLY + 1;
        forever begin
            @(negedge clk);
            since++;
            if (!rst_n) begin
                outst = 0;
                since = 0;
                want = INIT_DLY + 1;
                continue;
            end
            chk("busy_and_done", {31'd0, cfg_busy & cfg_done}, 0);
            if (req) begin
                chk("req_while_outstanding", {31'd0, outst}, 0);
                chk("req_spacing", since, want);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte_extra: got %0h want none", {cmd, din});
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", {2'b00, lut_index, cmd, din}, e);
                end
                outst = 1;
                held = {cmd, din};
            end else if (outst) begin
                chk("hold_cmd_din", {cmd, din}, held);
            end
            if (done && outst) begin
                outst = 0;
                since = 0;
                want = held[11] ? GAP_CYC + 2 : 1;
            end
            if (cfg_start && cfg_done && !cfg_busy) begin
                since = 0;
                want = INIT_DLY + 1;
            end
            if (req8) begin
                if (exp8_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte8_extra: got %0h want none", {cmd8, din8});
                end else begin
                    e8 = exp8_q.pop_front();
                    chk("byte8", {cmd8, din8}, e8);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {cfg_busy, cfg_done, cfg_err, req}, 0);
        chk("rst_bus", {cmd, din}, 0);
        chk("rst_idx_err", {err_cnt, lut_index}, 0);
        chk("rst_dut8", {busy8, done8, err8, req8, cmd8, din8, errc8, idx8}, 0);
        build_main();
        build8();
        slave_log.delete();
        log8.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        repeat (3) @(posedge clk);
        #1;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("start_done_clr", {31'd0, cfg_done}, 0);
        chk("start_busy", {31'd0, cfg_busy}, 1);
        chk("start_err_clr", {cfg_err, err_cnt}, 0);
    endtask

    task automatic poke_busy();
        repeat ($urandom_range(5, 60)) @(posedge clk);
        #1;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got cfg_done=0 want 1", name);
        end
    endtask

    task automatic end_check(input string name);
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_done"}, {cfg_done, cfg_busy}, 2'b10);
        chk({name, "_err"}, {31'd0, cfg_err}, (exp_err != 0) ? 1 : 0);
        chk({name, "_errcnt"}, {24'd0, err_cnt}, exp_err);
        chk({name, "_idx"}, {30'd0, lut_index}, REG_NUM - 1);
    endtask

    task automatic check8(input string name);
        int n;
        n = 0;
        while (!done8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done8"}, {busy8, done8, err8}, 3'b010);
        chk({name, "_left8"}, exp8_q.size(), 0);
    endtask

    task automatic rand_table();
        for (int i = 0; i < REG_NUM; i++) tbl[i] = 24'($urandom);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] lit_a [12];
    logic [7:0] lit_8 [9];
    int hits;

    initial begin : driver
        lit_a = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h31, 8'h03, 8'h03, 8'h78, 8'h30, 8'h17, 8'hFF};
        lit_8 = '{8'h78, 8'h12, 8'h80, 8'h78, 8'h34, 8'h55, 8'h78, 8'hFF, 8'h01};
        tbl[0] = 24'h300882; tbl[1] = 24'h310303; tbl[2] = 24'h3017FF;
        tbl8[0] = 24'h001280; tbl8[1] = 24'h003455; tbl8[2] = 24'h00FF01;
        for (int i = 0; i < REG_NUM; i++) nack_times[i] = 0;

        // Fixed table after reset, all ACK; pin bytes against hand values.
        do_reset();
        wait_done("run1");
        end_check("run1");
        check8("run1");
        chk("run1_nbytes", slave_log.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < slave_log.size()) chk("run1_lit", {24'd0, slave_log[i]}, {24'd0, lit_a[i]});
        chk("run8_nbytes", log8.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < log8.size()) chk("run8_lit", {24'd0, log8[i]}, {24'd0, lit_8[i]});

        // Entry 1 NACKed once: resent once, no error; extra start while busy.
        rand_table();
        nack_times[0] = 0; nack_times[1] = 1; nack_times[2] = 0;
        build_main();
        pulse_start();
        poke_busy();
        wait_done("run2");
        end_check("run2");

        // Entry 1 always NACKed: 4 attempts, skipped, entry 2 still written.
        rand_table();
        nack_times[1] = 9;
        build_main();
        chk("model_err", exp_err, 1);
        pulse_start();
        wait_done("run3");
        end_check("run3");

        // Random tables and NACK patterns (start also clears err state).
        for (int r = 0; r < 5; r++) begin
            rand_table();
            for (int i = 0; i < REG_NUM; i++) nack_times[i] = $urandom_range(0, 5);
            build_main();
            pulse_start();
            if ($urandom_range(0, 1) == 1) poke_busy();
            wait_done("runr");
            end_check("runr");
        end

        // Reset while entry 1's RADDR_L byte is in flight: restart from entry 0.
        rand_table();
        for (int i = 0; i < REG_NUM; i++) nack_times[i] = 0;
        build_main();
        pulse_start();
        hits = 0;
        for (int n = 0; n < 3000 && hits < 2; n++) begin
            @(negedge clk);
            if (dbg_state == ST_RADDR_L && req) hits++;
        end
        chk("raddr_l_reached", hits, 2);
        do_reset();
        wait_done("run_rst");
        end_check("run_rst");
        check8("run_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
